// File: rtl/mldsa_arb_pkg.sv
// rtl/mldsa_arb_pkg.sv - shared FSM state type and AHB transfer-type constants for the ML-DSA AHB arbiter
package mldsa_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

endpackage

// File: rtl/mldsa_rr_picker.sv
// rtl/mldsa_rr_picker.sv - combinational round-robin picker: first set request at or after rr_ptr_i
module mldsa_rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic                       valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [IW:0]          sum;

  // Rotating the doubled vector puts rr_ptr_i at bit 0; scanning from the top
  // lets the lowest offset overwrite, so the nearest requester wins.
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    sum     = '0;
    dbl     = {req_i, req_i} >> rr_ptr_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      if (|(dbl & ((2*NUM_REQ)'(1) << i))) begin
        valid_o = 1'b1;
        grant_o = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mldsa_ahb_arbiter.sv
// rtl/mldsa_ahb_arbiter.sv - round-robin req/ack to AHB-lite master arbiter for the ML-DSA slave port
// Optional grant locking for atomic multi-word loads is enabled by defining MLDSA_ARB_LOCK_EN.
module mldsa_ahb_arbiter
  import mldsa_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int AHB_ADDR_WIDTH = 18,
  parameter int AHB_DATA_WIDTH = 64
) (
  input  logic                                          clk,
  input  logic                                          rst_b,
  input  logic [NUM_REQ-1:0]                            req_i,
  input  logic [NUM_REQ-1:0]                            write_i,
  input  logic [NUM_REQ-1:0][2:0]                       size_i,
  input  logic [NUM_REQ-1:0][AHB_ADDR_WIDTH-1:0]        addr_i,
  input  logic [NUM_REQ-1:0][AHB_DATA_WIDTH-1:0]        wdata_i,
  input  logic [NUM_REQ-1:0]                            lock_i,
  output logic [NUM_REQ-1:0]                            ack_o,
  output logic [AHB_DATA_WIDTH-1:0]                     rdata_o,
  output logic                                          err_o,
  output logic [AHB_ADDR_WIDTH-1:0]                     haddr_o,
  output logic [AHB_DATA_WIDTH-1:0]                     hwdata_o,
  output logic                                          hsel_o,
  output logic                                          hwrite_o,
  output logic [1:0]                                    htrans_o,
  output logic [2:0]                                    hsize_o,
  output logic                                          hready_o,
  input  logic                                          hresp_i,
  input  logic                                          hreadyout_i,
  input  logic [AHB_DATA_WIDTH-1:0]                     hrdata_i
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e                state_q;
  logic [IW-1:0]             rr_ptr_q;
  logic [IW-1:0]             rr_ptr_d;
  logic [IW-1:0]             grant_q;
  logic [IW-1:0]             grant_d;
  logic                      start_d;
  logic                      pick_valid;
  logic [IW-1:0]             pick_grant;
  logic [NUM_REQ-1:0]        ack_q;
  logic [AHB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic [AHB_ADDR_WIDTH-1:0] haddr_q;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q;
  logic                      hsel_q;
  logic                      hwrite_q;
  logic [1:0]                htrans_q;
  logic [2:0]                hsize_q;

`ifdef MLDSA_ARB_LOCK_EN
  logic                      lock_q;
`else
  logic                      unused_lock;
  assign unused_lock = ^lock_i;
`endif

  mldsa_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .grant_o  (pick_grant)
  );

  assign rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // A held lock bypasses the rotation: only the locked requester may start.
  always_comb begin
    start_d = pick_valid;
    grant_d = pick_grant;
`ifdef MLDSA_ARB_LOCK_EN
    if (lock_q) begin
      start_d = req_i[grant_q];
      grant_d = grant_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hsel_q   <= 1'b0;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hsize_q  <= '0;
`ifdef MLDSA_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            grant_q  <= grant_d;
            haddr_q  <= addr_i[grant_d];
            hwrite_q <= write_i[grant_d];
            hsize_q  <= size_i[grant_d];
            hwdata_q <= wdata_i[grant_d];
            hsel_q   <= 1'b1;
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          if (hreadyout_i) begin
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (hreadyout_i) begin
            rdata_q <= hrdata_i;
            err_q   <= hresp_i;
            ack_q   <= NUM_REQ'(1) << grant_q;
            state_q <= RESP;
          end
        end
        RESP: begin
`ifdef MLDSA_ARB_LOCK_EN
          lock_q <= lock_i[grant_q];
          if (!lock_i[grant_q]) begin
            rr_ptr_q <= rr_ptr_d;
          end
`else
          rr_ptr_q <= rr_ptr_d;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign haddr_o  = haddr_q;
  assign hwdata_o = hwdata_q;
  assign hsel_o   = hsel_q;
  assign hwrite_o = hwrite_q;
  assign htrans_o = htrans_q;
  assign hsize_o  = hsize_q;
  assign hready_o = hreadyout_i;

endmodule

// File: tb/tb_mldsa_ahb_arbiter.sv
// tb/tb_mldsa_ahb_arbiter.sv - randomized self-checking bench for mldsa_ahb_arbiter against a transfer-timeline model
`timescale 1ns/1ps
module tb_mldsa_ahb_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int AW = 18;
  localparam int DW = 64;
`ifdef MLDSA_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_b;
  logic [N-1:0]         req, wr, lock;
  logic [N-1:0][2:0]    size;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0]         ack_o;
  logic [DW-1:0]        rdata_o, hwdata_o, hrdata;
  logic                 err_o, hsel_o, hwrite_o, hready_o, hresp, hreadyout;
  logic [AW-1:0]        haddr_o;
  logic [1:0]           htrans_o;
  logic [2:0]           hsize_o;

  mldsa_ahb_arbiter #(
    .NUM_REQ        (N),
    .AHB_ADDR_WIDTH (AW),
    .AHB_DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_i       (req),
    .write_i     (wr),
    .size_i      (size),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .lock_i      (lock),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .haddr_o     (haddr_o),
    .hwdata_o    (hwdata_o),
    .hsel_o      (hsel_o),
    .hwrite_o    (hwrite_o),
    .htrans_o    (htrans_o),
    .hsize_o     (hsize_o),
    .hready_o    (hready_o),
    .hresp_i     (hresp),
    .hreadyout_i (hreadyout),
    .hrdata_i    (hrdata)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            busy, ack_cyc;
  int            t0, wa, wd, w;
  logic [IW-1:0] wi;
  logic [DW-1:0] s_rdata, last_rdata, f_rdata;
  bit            s_resp, last_err, f_resp, f_data;
  int            m_ptr, m_lw;
  bit            m_lock;
  int            p_raise, p_keep, max_wait, f_wa, f_wd;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic new_payload(input int i);
    addr[IW'(i)]  = AW'($urandom);
    wr[IW'(i)]    = 1'($urandom_range(0, 1));
    size[IW'(i)]  = 3'($urandom_range(0, 3));
    wdata[IW'(i)] = {$urandom, $urandom};
    lock[IW'(i)]  = ($urandom_range(0, 3) == 0);
  endtask

  // Outputs expected from the transfer timeline: address phase 1..1+wa,
  // data phase up to 2+wa+wd, completion pulse one cycle later.
  task automatic check_cycle();
    int           rel;
    logic [N-1:0] oh;
    ack_cyc = 1'b0;
    if (busy) begin
      rel = cyc - t0;
      if (rel <= 1 + wa) begin
        check("htrans_addr", 64'(htrans_o), 64'(2'b10));
        check("hsel_addr", 64'(hsel_o), 64'(1));
        check("haddr", 64'(haddr_o), 64'(addr[wi]));
        check("hwrite", 64'(hwrite_o), 64'(wr[wi]));
        check("hsize", 64'(hsize_o), 64'(size[wi]));
        check("ack_addr", 64'(ack_o), 64'(0));
      end else if (rel <= 2 + wa + wd) begin
        check("htrans_data", 64'(htrans_o), 64'(2'b00));
        check("hsel_data", 64'(hsel_o), 64'(0));
        check("hwdata", hwdata_o, wdata[wi]);
        check("ack_data", 64'(ack_o), 64'(0));
      end else begin
        oh = '0;
        oh[wi] = 1'b1;
        check("ack_grant", 64'(ack_o), 64'(oh));
        check("rdata", rdata_o, s_rdata);
        check("err", 64'(err_o), 64'(s_resp));
        check("htrans_resp", 64'(htrans_o), 64'(2'b00));
        last_rdata = s_rdata;
        last_err   = s_resp;
        m_lock     = LOCK_EN && lock[wi];
        m_lw       = w;
        if (!m_lock) m_ptr = (w + 1) % N;
        if ($urandom_range(0, 99) < p_keep) new_payload(w);
        else req[wi] = 1'b0;
        busy    = 1'b0;
        ack_cyc = 1'b1;
      end
    end else begin
      check("ack_idle", 64'(ack_o), 64'(0));
      check("htrans_idle", 64'(htrans_o), 64'(2'b00));
      check("hsel_idle", 64'(hsel_o), 64'(0));
      check("rdata_hold", rdata_o, last_rdata);
      check("err_hold", 64'(err_o), 64'(last_err));
    end
  endtask

  task automatic drive_cycle();
    int rel;
    for (int i = 0; i < N; i++) begin
      if (!req[IW'(i)] && $urandom_range(0, 99) < p_raise) begin
        new_payload(i);
        req[IW'(i)] = 1'b1;
      end
    end
    if (!busy && !ack_cyc) begin
      w = -1;
      if (m_lock) begin
        if (req[IW'(m_lw)]) w = m_lw;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[IW'((m_ptr + k) % N)]) w = (m_ptr + k) % N;
        end
      end
      if (w >= 0) begin
        busy    = 1'b1;
        wi      = IW'(w);
        t0      = cyc;
        wa      = (f_wa >= 0) ? f_wa : $urandom_range(0, max_wait);
        wd      = (f_wd >= 0) ? f_wd : $urandom_range(0, max_wait);
        s_rdata = f_data ? f_rdata : {$urandom, $urandom};
        s_resp  = f_data ? f_resp : ($urandom_range(0, 3) == 0);
      end
    end
    hreadyout = 1'($urandom_range(0, 1));
    hrdata    = {$urandom, $urandom};
    hresp     = 1'($urandom_range(0, 1));
    if (busy) begin
      rel = cyc - t0;
      if (rel >= 1 && rel <= 1 + wa) begin
        hreadyout = (rel == 1 + wa);
      end else if (rel >= 2 + wa && rel <= 2 + wa + wd) begin
        hreadyout = (rel == 2 + wa + wd);
        if (hreadyout) begin
          hrdata = s_rdata;
          hresp  = s_resp;
        end
      end
    end
    #1;
    check("hready_follow", 64'(hready_o), 64'(hreadyout));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    drive_cycle();
  endtask

  task automatic issue(input int i, input bit wr_, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[IW'(i)]  = a;
    wr[IW'(i)]    = wr_;
    size[IW'(i)]  = 3'd3;
    wdata[IW'(i)] = d;
    lock[IW'(i)]  = 1'b0;
    req[IW'(i)]   = 1'b1;
    drive_cycle();
  endtask

  initial begin
    bit found;
    rst_b = 1'b0; req = '0; wr = '0; lock = '0; size = '0; addr = '0; wdata = '0;
    hresp = 1'b0; hreadyout = 1'b1; hrdata = '0;
    busy = 1'b0; ack_cyc = 1'b0; m_ptr = 0; m_lock = 1'b0; m_lw = 0; w = 0; wi = '0;
    last_rdata = '0; last_err = 1'b0;
    p_raise = 0; p_keep = 0; max_wait = 0; f_wa = -1; f_wd = -1; f_data = 1'b0;
    f_rdata = '0; f_resp = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_htrans", 64'(htrans_o), 64'(0));
    check("rst_hsel", 64'(hsel_o), 64'(0));
    check("rst_ack", 64'(ack_o), 64'(0));
    check("rst_rdata", rdata_o, 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_haddr", 64'(haddr_o), 64'(0));
    check("rst_hwdata", hwdata_o, 64'(0));
    check("rst_hready1", 64'(hready_o), 64'(1));
    hreadyout = 1'b0;
    #1;
    check("rst_hready0", 64'(hready_o), 64'(0));
    rst_b = 1'b1;

    // Single zero-wait read from requester 0.
    f_wa = 0; f_wd = 0; f_data = 1'b1; f_rdata = 64'hDEAD_BEEF_0123_4567; f_resp = 1'b0;
    issue(0, 1'b0, 18'h00040, 64'h0);
    repeat (6) step();

    // Write with three data-phase wait states.
    f_wd = 3; f_data = 1'b0;
    issue(1, 1'b1, 18'h00100, 64'h1234);
    repeat (9) step();

    // Error response followed by an ordinary transfer.
    f_wd = 0; f_data = 1'b1; f_rdata = 64'h0BAD_0BAD_0BAD_0BAD; f_resp = 1'b1;
    issue(2, 1'b0, 18'h00200, 64'h0);
    repeat (6) step();
    f_resp = 1'b0; f_rdata = 64'h1111_2222_3333_4444;
    issue(0, 1'b0, 18'h00208, 64'h0);
    repeat (6) step();

    // Contention: every requester held, then drained.
    f_data = 1'b0; p_keep = 100;
    for (int i = 0; i < N; i++) begin
      addr[IW'(i)] = AW'(i * 16); wr[IW'(i)] = 1'b0; size[IW'(i)] = 3'd3; lock[IW'(i)] = 1'b0;
      req[IW'(i)] = 1'b1;
    end
    drive_cycle();
    repeat (16) step();
    p_keep = 0;
    repeat (20) step();

    // Randomized traffic.
    f_wa = -1; f_wd = -1; p_raise = 25; p_keep = 50; max_wait = 3;
    repeat (1500) step();

    // Reset while a transfer sits in its data phase.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (busy && (cyc - t0) >= 2 + wa && (cyc - t0) <= 2 + wa + wd) found = 1'b1;
    end
    check("reset_window", 64'(found), 64'(1));
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check("abort_htrans", 64'(htrans_o), 64'(0));
    check("abort_hsel", 64'(hsel_o), 64'(0));
    check("abort_ack", 64'(ack_o), 64'(0));
    check("abort_rdata", rdata_o, 64'(0));
    check("abort_err", 64'(err_o), 64'(0));
    rst_b = 1'b1;
    busy = 1'b0; ack_cyc = 1'b0; m_ptr = 0; m_lock = 1'b0;
    last_rdata = '0; last_err = 1'b0;
    drive_cycle();
    repeat (500) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
